// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the gray_counter encode path
// and its matching receivers.
package gray_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_e;

   function automatic logic [15:0] bin2gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of every Gray bit at or above it, so walk down from the MSB.
   function automatic logic [15:0] gray2bin(input logic [15:0] g);
      logic [15:0] b;
      b[15] = g[15];
      for (int i = 14; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder; mirror of the Gray-to-binary converter.
module bin_to_gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Binary counter with a registered, glitch-free Gray-code output for CDC FIFO pointers.
// Define GRAY_CNT_UPDOWN_EN to add the dir input and down-counting.
module gray_counter
   import gray_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef GRAY_CNT_UPDOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

   logic [WIDTH-1:0] next_bin;
   logic [WIDTH-1:0] next_gray;
   logic             next_wrap;

   // Wrap is judged from the value being left, so no carry flop is needed.
   always_comb begin
      next_bin  = bin_out;
      next_wrap = 1'b0;
      if (load) begin
         next_bin = load_val;
      end else if (en) begin
`ifdef GRAY_CNT_UPDOWN_EN
         if (cnt_dir_e'(dir) == CNT_DOWN) begin
            next_bin  = bin_out - WIDTH'(1);
            next_wrap = (bin_out == '0);
         end else begin
            next_bin  = bin_out + WIDTH'(1);
            next_wrap = (bin_out == ALL_ONES);
         end
`else
         next_bin  = bin_out + WIDTH'(1);
         next_wrap = (bin_out == ALL_ONES);
`endif
      end
   end

   // Encoding the next value keeps gray_out a plain flop output with no decode glitches.
   bin_to_gray #(
      .WIDTH (WIDTH)
   ) u_bin_to_gray (
      .bin  (next_bin),
      .gray (next_gray)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_out  <= RST_VAL;
         gray_out <= RST_GRAY;
         wrap     <= 1'b0;
      end else begin
         bin_out  <= next_bin;
         gray_out <= next_gray;
         wrap     <= next_wrap;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=4; down-count checks run only with GRAY_CNT_UPDOWN_EN.
module tb_gray_counter;
   import gray_pkg::*;

`ifdef GRAY_CNT_UPDOWN_EN
   localparam bit UPDOWN = 1'b1;
`else
   localparam bit UPDOWN = 1'b0;
`endif

   typedef struct {
      logic [3:0] bin;
      logic [3:0] gray;
      logic       wrap;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       load;
   logic [3:0] load_val;
   logic       dir;
   logic [3:0] bin_out;
   logic [3:0] gray_out;
   logic       wrap;

   int   checks;
   int   errors;
   exp_t sb[$];
   logic [3:0] model_bin;
   logic [3:0] prev_gray;

   gray_counter #(
      .WIDTH   (4),
      .RST_VAL (4'd0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (load),
      .load_val (load_val),
`ifdef GRAY_CNT_UPDOWN_EN
      .dir      (dir),
`endif
      .bin_out  (bin_out),
      .gray_out (gray_out),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle, predicts the result, queues it and samples 1 time unit after the edge.
   task automatic applyStimulus(input logic r_n, input logic e, input logic l,
                                input logic [3:0] lv, input logic d);
      exp_t x;
      x.wrap = 1'b0;
      if (!r_n) begin
         model_bin = 4'd0;
      end else if (l) begin
         model_bin = lv;
      end else if (e) begin
         if (UPDOWN && d) begin
            x.wrap    = (model_bin == 4'd0);
            model_bin = model_bin - 4'd1;
         end else begin
            x.wrap    = (model_bin == 4'hF);
            model_bin = model_bin + 4'd1;
         end
      end
      x.bin  = model_bin;
      x.gray = model_bin ^ (model_bin >> 1);
      sb.push_back(x);
      rst_n    = r_n;
      en       = e;
      load     = l;
      load_val = lv;
      dir      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t x;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
         x = sb.pop_front();
         checks++;
         if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
            errors++;
            $display("[TB] FAIL reset bin=%h gray=%b wrap=%b expected bin=%h gray=%b wrap=%b",
                     bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
         end
      end
      prev_gray = 4'b0000;
   endtask

   task automatic test_up_count();
      exp_t x;
      logic [3:0] gray_table [16];
      gray_table = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
         x = sb.pop_front();
         checks++;
         if (bin_out !== 4'(i) || gray_out !== gray_table[i] || wrap !== 1'b0 || x.bin !== 4'(i)) begin
            errors++;
            $display("[TB] FAIL up_count step %0d bin=%h gray=%b wrap=%b expected bin=%h gray=%b wrap=0",
                     i, bin_out, gray_out, wrap, 4'(i), gray_table[i]);
         end
         checks++;
         if ($countones(gray_out ^ prev_gray) != 1) begin
            errors++;
            $display("[TB] FAIL gray_hamming step %0d gray=%b prev=%b expected one bit change",
                     i, gray_out, prev_gray);
         end
         prev_gray = x.gray;
      end
   endtask

   task automatic test_wrap();
      exp_t x;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
         x = sb.pop_front();
         checks++;
         if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap || wrap !== (i == 0)) begin
            errors++;
            $display("[TB] FAIL wrap step %0d bin=%h gray=%b wrap=%b expected bin=%h gray=%b wrap=%b",
                     i, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
         end
         checks++;
         if ($countones(gray_out ^ prev_gray) != 1) begin
            errors++;
            $display("[TB] FAIL gray_hamming_wrap gray=%b prev=%b expected one bit change", gray_out, prev_gray);
         end
         prev_gray = x.gray;
      end
   endtask

   task automatic test_load_priority();
      exp_t x;
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
      x = sb.pop_front();
      checks++;
      if (bin_out !== 4'd9 || gray_out !== 4'b1101 || wrap !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_9 bin=%h gray=%b wrap=%b expected bin=9 gray=1101 wrap=0",
                  bin_out, gray_out, wrap);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
      x = sb.pop_front();
      checks++;
      if (bin_out !== 4'd15 || gray_out !== 4'b1000 || wrap !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_15 bin=%h gray=%b wrap=%b expected bin=f gray=1000 wrap=0",
                  bin_out, gray_out, wrap);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      x = sb.pop_front();
      checks++;
      if (bin_out !== x.bin || gray_out !== x.gray || wrap !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wrap_after_load bin=%h gray=%b wrap=%b expected bin=%h gray=%b wrap=1",
                  bin_out, gray_out, wrap, x.bin, x.gray);
      end
   endtask

   task automatic test_hold_and_reset();
      exp_t x;
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
      x = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd12, 1'b0);
         x = sb.pop_front();
         checks++;
         if (bin_out !== 4'd5 || gray_out !== 4'b0111 || wrap !== 1'b0 || x.bin !== 4'd5) begin
            errors++;
            $display("[TB] FAIL hold cycle %0d bin=%h gray=%b wrap=%b expected bin=5 gray=0111 wrap=0",
                     i, bin_out, gray_out, wrap);
         end
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      x = sb.pop_front();
      checks++;
      if (bin_out !== 4'd6 || gray_out !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL step_to_6 bin=%h gray=%b expected bin=6 gray=0101", bin_out, gray_out);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      x = sb.pop_front();
      checks++;
      if (bin_out !== 4'd0 || gray_out !== 4'b0000 || wrap !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset bin=%h gray=%b wrap=%b expected bin=0 gray=0000 wrap=0",
                  bin_out, gray_out, wrap);
      end
   endtask

   task automatic test_down_count();
      exp_t x;
      logic [3:0] want_bin  [3];
      logic [3:0] want_gray [3];
      logic       want_wrap [3];
      logic       dirs      [3];
      want_bin  = '{4'd15, 4'd14, 4'd15};
      want_gray = '{4'b1000, 4'b1001, 4'b1000};
      want_wrap = '{1'b1, 1'b0, 1'b0};
      dirs      = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, dirs[i]);
         x = sb.pop_front();
         checks++;
         if (bin_out !== want_bin[i] || gray_out !== want_gray[i] || wrap !== want_wrap[i]) begin
            errors++;
            $display("[TB] FAIL down_count step %0d bin=%h gray=%b wrap=%b expected bin=%h gray=%b wrap=%b",
                     i, bin_out, gray_out, wrap, want_bin[i], want_gray[i], want_wrap[i]);
         end
      end
   endtask

   task automatic test_round_trip();
      exp_t x;
      logic [15:0] decoded;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         x = sb.pop_front();
         decoded = gray2bin({12'd0, gray_out});
         checks++;
         if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap || decoded[3:0] !== x.bin) begin
            errors++;
            $display("[TB] FAIL round_trip cycle %0d bin=%h gray=%b decoded=%h wrap=%b expected bin=%h gray=%b wrap=%b",
                     i, bin_out, gray_out, decoded[3:0], wrap, x.bin, x.gray, x.wrap);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      model_bin = 4'd0;
      prev_gray = 4'd0;
      rst_n     = 1'b0;
      en        = 1'b0;
      load      = 1'b0;
      load_val  = 4'd0;
      dir       = 1'b0;
      test_reset();
      test_up_count();
      test_wrap();
      test_load_priority();
      test_hold_and_reset();
      if (UPDOWN) test_down_count();
      test_round_trip();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
